// File: rtl/neosd_dat_buf_if.sv
// Bundled data-buffer signals: bus side, DAT FSM side, control strobes and status.
// The slave modport is the buffer itself; the master modport drives it.
interface neosd_dat_buf_if #(
    parameter int DEPTH_LOG2 = 7
);
    logic                  flush_i;
    logic                  dir_i;
    logic [31:0]           bus_dat_i;
    logic                  bus_wr_i;
    logic                  bus_rd_i;
    logic [31:0]           bus_dat_o;
    logic [31:0]           fsm_dat_i;
    logic                  fsm_push_i;
    logic                  fsm_pop_i;
    logic [31:0]           fsm_dat_o;
    logic [DEPTH_LOG2:0]   level_o;
    logic                  empty_o;
    logic                  full_o;
    logic                  half_o;
    logic                  ovf_o;
    logic                  udf_o;

    modport slave (
        input  flush_i, dir_i, bus_dat_i, bus_wr_i, bus_rd_i,
        input  fsm_dat_i, fsm_push_i, fsm_pop_i,
        output bus_dat_o, fsm_dat_o, level_o,
        output empty_o, full_o, half_o, ovf_o, udf_o
    );

    modport master (
        output flush_i, dir_i, bus_dat_i, bus_wr_i, bus_rd_i,
        output fsm_dat_i, fsm_push_i, fsm_pop_i,
        input  bus_dat_o, fsm_dat_o, level_o,
        input  empty_o, full_o, half_o, ovf_o, udf_o
    );
endinterface

// File: rtl/neosd_dat_buf.sv
// Bidirectional first-word-fall-through data buffer between the bus and the SD DAT FSM.
// Direction selects which side pushes and which side pops; status derives from registered state.
module neosd_dat_buf #(
    parameter int DEPTH_LOG2 = 7,
    parameter int HALF_MARK  = 64
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    neosd_dat_buf_if.slave        io
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          push_req, pop_req;
    logic [31:0]   push_dat;
    logic          empty, full;
    logic          push_ok, pop_ok;
    logic          ovf_set, udf_set;
    logic          mem_we;

    // The inactive side's strobes are simply not selected, so they never raise a flag.
    assign push_req = io.dir_i ? io.fsm_push_i : io.bus_wr_i;
    assign push_dat = io.dir_i ? io.fsm_dat_i  : io.bus_dat_i;
    assign pop_req  = io.dir_i ? io.bus_rd_i   : io.fsm_pop_i;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));

    // A pop in the same cycle frees the slot, so a push while full is still taken.
    assign push_ok = push_req && (!full || pop_req);
    assign pop_ok  = pop_req && !empty;
    assign ovf_set = push_req && full && !pop_req;
    assign udf_set = pop_req && empty;
    assign mem_we  = push_ok && !io.flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | ovf_set;
        udf_d    = udf_q | udf_set;
        if (io.flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[wr_ptr_q] <= push_dat;
    end

    assign io.bus_dat_o = mem_q[rd_ptr_q];
    assign io.fsm_dat_o = mem_q[rd_ptr_q];
    assign io.level_o   = level_q;
    assign io.empty_o   = empty;
    assign io.full_o    = full;
    assign io.half_o    = (level_q >= LW'(HALF_MARK));
    assign io.ovf_o     = ovf_q;
    assign io.udf_o     = udf_q;
endmodule

// File: doc/neosd_dat_buf.md
NEOSD_DAT_BUF -- requirements
Module: neosd_dat_buf

Interface
REQ-001 Parameter DEPTH_LOG2, default 7, log2 of buffer depth in 32-bit words (128 words = one 512-byte block).
REQ-002 Parameter HALF_MARK, default 64, fill level at or above which half_o asserts.
REQ-003 clk_i  in  1  system clock; all state advances on its rising edge.
REQ-004 rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 flush_i  in  1  synchronous flush: empties the buffer and clears error flags.
REQ-006 dir_i  in  1  direction: 0 = TX (bus fills, DAT FSM drains), 1 = RX (DAT FSM fills, bus drains).
REQ-007 bus_dat_i  in  32  bus write word.
REQ-008 bus_wr_i  in  1  bus push strobe, one word per cycle.
REQ-009 bus_rd_i  in  1  bus pop strobe, one word per cycle.
REQ-010 bus_dat_o  out  32  head word for the bus side.
REQ-011 fsm_dat_i  in  32  DAT FSM received word.
REQ-012 fsm_push_i  in  1  DAT FSM push strobe.
REQ-013 fsm_pop_i  in  1  DAT FSM pop strobe.
REQ-014 fsm_dat_o  out  32  head word for the DAT FSM side.
REQ-015 level_o  out  DEPTH_LOG2+1  current word count, 0..2^DEPTH_LOG2.
REQ-016 empty_o, full_o, half_o  out  1 each  level == 0, level == depth, level >= HALF_MARK.
REQ-017 ovf_o, udf_o  out  1 each  sticky overflow and underflow flags.

Function
REQ-018 Push source SHALL be bus_wr_i/bus_dat_i when dir_i=0 and fsm_push_i/fsm_dat_i when dir_i=1; the other push strobe is ignored with no flag.
REQ-019 Pop source SHALL be fsm_pop_i when dir_i=0 and bus_rd_i when dir_i=1; the other pop strobe is ignored with no flag.
REQ-020 Storage SHALL be first-word-fall-through: bus_dat_o and fsm_dat_o both show mem[rd_ptr] combinationally, valid while empty_o=0, value unspecified when empty.
REQ-021 An accepted push SHALL write mem[wr_ptr] and increment wr_ptr modulo depth in the same cycle; zero added latency, so the word is visible at the head the next cycle when the buffer was empty.
REQ-022 An accepted pop SHALL increment rd_ptr modulo depth; the next head word is visible the following cycle.
REQ-023 Pointers SHALL be DEPTH_LOG2 bits and wrap from depth-1 to 0; level SHALL be a separate counter of DEPTH_LOG2+1 bits.
REQ-024 Push while full with no pop: word dropped, pointers and level unchanged, ovf_o set.
REQ-025 Pop while empty: ignored, udf_o set.
REQ-026 Push and pop in the same cycle while full: both accepted, level unchanged, no overflow.
REQ-027 Push and pop in the same cycle while empty: push accepted, pop ignored, udf_o set, level becomes 1.
REQ-028 Push and pop in the same cycle otherwise: both accepted, level unchanged.
REQ-029 flush_i SHALL take priority over every strobe in its cycle: rd_ptr = wr_ptr = 0, level = 0, ovf_o = udf_o = 0, and any push or pop in that cycle is discarded.
REQ-030 A change of dir_i SHALL NOT alter contents or pointers; software flushes before reversing direction.
REQ-031 All status outputs SHALL be derived from registered state and SHALL be valid in the cycle after the causing edge.

Reset
REQ-032 While rstn_i=0: rd_ptr = wr_ptr = 0, level_o = 0, empty_o = 1, full_o = 0, half_o = 0, ovf_o = 0, udf_o = 0; memory contents are not reset.
REQ-033 Deassertion of rstn_i mid-transfer SHALL leave the buffer empty; strobes are honoured from the first clock edge after release.

Verification
REQ-034 TX fill: dir=0, 128 bus_wr pushes of 0..127 -> level 128, full=1, half=1 from the 64th push; then 128 fsm_pop cycles return 0..127 in order -> empty=1, ovf=udf=0.
REQ-035 Overflow: full buffer, one extra bus_wr of 0xDEADBEEF -> ovf=1, level stays 128, head still 0x00000000; simultaneous push+pop while full -> level 128, no new ovf event.
REQ-036 Underflow: empty, dir=1, bus_rd=1 -> udf=1, level 0; same cycle fsm_push of 0xA5A5A5A5 -> level 1, bus_dat_o = 0xA5A5A5A5 next cycle.
REQ-037 Wrap: push 100, pop 100, push 60 -> level 60, data order preserved across the pointer wrap at 127->0.
REQ-038 Flush: level 37 with ovf=1, flush_i with a simultaneous push -> next cycle level 0, empty=1, ovf=0, pushed word discarded.
REQ-039 Async reset: assert rstn_i low between clock edges at level 90 -> empty=1 and level 0 immediately, without waiting for a clock edge.
